// File: rtl/write_back_gen.sv
// Writeback controller: init/conv/accumulate/swap/drain sequencing plus a registered row-to-port mux.
// Optional feature macro: WB_RELU_EN (clamp negative forwarded values to zero).
module write_back_gen #(
  parameter int unsigned DATA_WIDTH = 25,
  parameter int unsigned DEPTH      = 62,
  parameter int unsigned NUM_ROWS   = 4,
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned PASS_W     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_init,
  input  logic [PASS_W-1:0]               cfg_passes,
  input  logic                            p_filter_end,
  input  logic [NUM_ROWS*DATA_WIDTH-1:0]  row_data,
  input  logic [NUM_ROWS-1:0]             row_valid,
  output logic                            p_init,
  output logic [NUM_ROWS-1:0]             p_write_zero,
  output logic                            start_conv,
  output logic                            odd_cnt,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_PORTS-1:0]            out_valid,
  output logic                            layer_done,
  output logic                            err_protocol
);

  localparam int unsigned NUM_GROUPS = NUM_ROWS / NUM_PORTS;
  localparam int unsigned CNT_W      = $clog2(DEPTH + 4);
  localparam int unsigned GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  localparam logic [CNT_W-1:0] CntInitEnd  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CntStartEnd = CNT_W'(DEPTH + 2);
  localparam logic [CNT_W-1:0] CntPhaseEnd = CNT_W'(DEPTH - 1);
  localparam logic [GRP_W-1:0] LastGroup   = GRP_W'(NUM_GROUPS - 1);

  typedef enum logic [3:0] {
    StIdle, StInit, StStart, StWaitFilt, StAdd, StWaitWr, StSwap, StDrain, StGap, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [GRP_W-1:0]   group_q;
  logic [PASS_W-1:0]  pass_cnt_q;
  logic [PASS_W-1:0]  passes_q;

  logic                            p_init_d;
  logic [NUM_ROWS-1:0]             p_write_zero_d;
  logic                            start_conv_d;
  logic                            odd_cnt_d;
  logic                            layer_done_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0] out_data_d;
  logic [NUM_PORTS-1:0]            out_valid_d;
  logic                            err_protocol_d;

  // State register with phase counter, group index and pass bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      group_q    <= '0;
      pass_cnt_q <= '0;
      passes_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
      if (state_q == StIdle && start_init) begin
        passes_q <= (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
      end
      if (state_q == StWaitFilt && p_filter_end) begin
        pass_cnt_q <= pass_cnt_q + PASS_W'(1);
      end else if (state_q == StDone) begin
        pass_cnt_q <= '0;
      end
      if (state_q == StSwap) begin
        group_q <= '0;
      end else if (state_q == StGap) begin
        group_q <= group_q + GRP_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start_init) state_d = StInit;
      // INIT keeps one settle cycle after the last zero push before conv starts.
      StInit:     if (cnt_q == CntInitEnd) state_d = StStart;
      StStart:    if (cnt_q == CntStartEnd) state_d = StWaitFilt;
      StWaitFilt: if (p_filter_end) state_d = StAdd;
      StAdd:      if (cnt_q == CntPhaseEnd) state_d = StWaitWr;
      StWaitWr:   state_d = StSwap;
      StSwap:     state_d = StDrain;
      StDrain: begin
        if (cnt_q == CntPhaseEnd) begin
          if (group_q != LastGroup)      state_d = StGap;
          else if (pass_cnt_q < passes_q) state_d = StWaitFilt;
          else                            state_d = StDone;
        end
      end
      StGap:      state_d = StDrain;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    p_init_d       = (state_q == StInit) && (cnt_q != CntInitEnd);
    start_conv_d   = (state_q == StStart) || (state_q == StSwap);
    odd_cnt_d      = odd_cnt ^ (state_q == StSwap);
    layer_done_d   = (state_q == StDone);
    p_write_zero_d = '0;
    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
      if (state_q == StDrain && group_q == GRP_W'(g)) begin
        p_write_zero_d[g*NUM_PORTS +: NUM_PORTS] = '1;
      end
    end
  end

  // Row-to-port mux: only an exact single-group valid mask is forwarded.
  always_comb begin
    logic                  hit;
    logic [NUM_ROWS-1:0]   mask;
    logic [DATA_WIDTH-1:0] val;
    hit         = 1'b0;
    mask        = '0;
    val         = '0;
    out_data_d  = '0;
    out_valid_d = '0;
    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
      mask = NUM_ROWS'({NUM_PORTS{1'b1}}) << (g * NUM_PORTS);
      if (row_valid == mask) begin
        hit         = 1'b1;
        out_valid_d = '1;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
          val = row_data[(g*NUM_PORTS + p)*DATA_WIDTH +: DATA_WIDTH];
`ifdef WB_RELU_EN
          if (val[DATA_WIDTH-1]) val = '0;
`endif
          out_data_d[p*DATA_WIDTH +: DATA_WIDTH] = val;
        end
      end
    end
    err_protocol_d = err_protocol | ((row_valid != '0) && !hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_init       <= 1'b0;
      p_write_zero <= '0;
      start_conv   <= 1'b0;
      odd_cnt      <= 1'b0;
      layer_done   <= 1'b0;
      out_data     <= '0;
      out_valid    <= '0;
      err_protocol <= 1'b0;
    end else begin
      p_init       <= p_init_d;
      p_write_zero <= p_write_zero_d;
      start_conv   <= start_conv_d;
      odd_cnt      <= odd_cnt_d;
      layer_done   <= layer_done_d;
      out_data     <= out_data_d;
      out_valid    <= out_valid_d;
      err_protocol <= err_protocol_d;
    end
  end

endmodule
